// File: rtl/tpu_pkg.sv
// Shared types and size helpers for the systolic-array sequencer.
// Element/period counts are derived from the array dimension N.
package tpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } seq_state_t;

  // Operand elements per matmul: A then B, each N*N.
  function automatic int unsigned elems_of(input int unsigned n);
    return 2 * n * n;
  endfunction

  function automatic int unsigned aw_of(input int unsigned n);
    return $clog2(2 * n * n);
  endfunction

  // First mmu_cycle at which the last result c[N-1][N-1] is valid.
  function automatic int unsigned res_off_of(input int unsigned n);
    return 3 * n - 2;
  endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-MOD counter with increment and synchronous clear; wraps explicitly
// at MOD-1 so MOD need not be a power of two.
module mod_counter #(
  parameter int unsigned MOD = 8,
  parameter int unsigned W   = $clog2(MOD)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] count_o,
  output logic         wrap_o
);

  localparam logic [W-1:0] LAST = W'(MOD - 1);

  logic [W-1:0] count_q, count_d;

  // Flags the increment that takes the count from MOD-1 back to 0.
  assign wrap_o  = inc_i && (count_q == LAST);
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i) begin
      count_d = (count_q == LAST) ? '0 : count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

endmodule

// File: rtl/tpu_seq_ctrl.sv
// Load/compute sequencer for an NxN systolic MMU with ping-pong operand banks:
// the next block loads into mem_bank_wr while the MMU reads mem_bank_rd.
module tpu_seq_ctrl
  import tpu_pkg::*;
#(
  parameter  int unsigned N     = 2,
  localparam int unsigned ELEMS = elems_of(N),
  localparam int unsigned P     = ELEMS,
  localparam int unsigned AW    = aw_of(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_en,
  input  logic          mode_cont,
  output logic          load_ready,
  output logic [AW-1:0] mem_addr,
  output logic          mem_bank_wr,
  output logic          mem_bank_rd,
  output logic          mmu_en,
  output logic [AW-1:0] mmu_cycle,
  output logic          res_valid,
  output logic          done,
  output logic          busy,
  output seq_state_t    dbg_state
);

  localparam logic [AW-1:0] RES_OFF = AW'(res_off_of(N));

  // Handshake: an element transfers on a rising edge where load_en and
  // load_ready are both 1; load_ready is a flop, so it never depends on load_en.
  seq_state_t    state_q, state_d;
  logic          full_q, full_d;
  logic          bank_wr_q, bank_wr_d, bank_rd_q, bank_rd_d;
  logic          load_ready_q, mmu_en_q, res_valid_q, done_q, busy_q;
  logic          accept, addr_wrap, addr_clr, cyc_inc, cyc_wrap, full_eff;
  logic [AW-1:0] addr_q, cyc_q, cyc_next;

  assign accept  = load_en && load_ready_q;
  assign cyc_inc = (state_q == ST_RUN);

  mod_counter #(.MOD(ELEMS), .W(AW)) u_addr (
    .clk     (clk),
    .rst_n   (rst),
    .inc_i   (accept),
    .clr_i   (addr_clr),
    .count_o (addr_q),
    .wrap_o  (addr_wrap)
  );

  mod_counter #(.MOD(P), .W(AW)) u_cyc (
    .clk     (clk),
    .rst_n   (rst),
    .inc_i   (cyc_inc),
    .clr_i   (1'b0),
    .count_o (cyc_q),
    .wrap_o  (cyc_wrap)
  );

  // mmu_cycle is only non-zero in RUN and leaves RUN only through the wrap.
  assign cyc_next = (cyc_inc && !cyc_wrap) ? cyc_q + AW'(1) : '0;

  always_comb begin
    state_d   = state_q;
    full_d    = full_q;
    bank_wr_d = bank_wr_q;
    bank_rd_d = bank_rd_q;
    addr_clr  = 1'b0;
    // The last element arriving on the wrap edge counts as a full next block.
    full_eff  = full_q || (accept && addr_wrap);
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (accept && addr_wrap) begin
          state_d   = ST_RUN;
          bank_rd_d = bank_wr_q;
          bank_wr_d = ~bank_wr_q;
        end
      end
      ST_RUN: begin
        if (accept && addr_wrap) full_d = 1'b1;
        if (cyc_wrap) begin
          full_d = 1'b0;
          if (full_eff) begin
            bank_rd_d = bank_wr_q;
            bank_wr_d = ~bank_wr_q;
          end else if (mode_cont) begin
            state_d = ST_LOAD;
          end else begin
            state_d  = ST_IDLE;
            addr_clr = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      full_q       <= 1'b0;
      bank_wr_q    <= 1'b0;
      bank_rd_q    <= 1'b0;
      load_ready_q <= 1'b0;
      mmu_en_q     <= 1'b0;
      res_valid_q  <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      full_q       <= full_d;
      bank_wr_q    <= bank_wr_d;
      bank_rd_q    <= bank_rd_d;
      load_ready_q <= (state_d != ST_RUN) || (mode_cont && !full_d);
      mmu_en_q     <= (state_d == ST_RUN);
      res_valid_q  <= (state_d == ST_RUN) && (cyc_next >= RES_OFF);
      done_q       <= (state_d == ST_RUN) && (cyc_next == RES_OFF);
      busy_q       <= (state_d != ST_IDLE);
    end
  end

  assign load_ready  = load_ready_q;
  assign mem_addr    = addr_q;
  assign mem_bank_wr = bank_wr_q;
  assign mem_bank_rd = bank_rd_q;
  assign mmu_en      = mmu_en_q;
  assign mmu_cycle   = cyc_q;
  assign res_valid   = res_valid_q;
  assign done        = done_q;
  assign busy        = busy_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_tpu_seq_ctrl.sv
// Bench for tpu_seq_ctrl: N=2 and N=3 instances driven by scenario tasks.
// Expected values come from the element count and cycles elapsed since RUN began.
module tb_tpu_seq_ctrl;
  import tpu_pkg::*;

  localparam int N2 = 2, E2 = 2 * N2 * N2, P2 = E2, OFF2 = 3 * N2 - 2;
  localparam int N3 = 3, E3 = 2 * N3 * N3, P3 = E3, OFF3 = 3 * N3 - 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic       load_en2 = 1'b0, mode_cont2 = 1'b0;
  logic       load_ready2, mem_bank_wr2, mem_bank_rd2, mmu_en2, res_valid2, done2, busy2;
  logic [2:0] mem_addr2, mmu_cycle2;
  seq_state_t dbg_state2;

  logic       load_en3 = 1'b0, mode_cont3 = 1'b0;
  logic       load_ready3, mem_bank_wr3, mem_bank_rd3, mmu_en3, res_valid3, done3, busy3;
  logic [4:0] mem_addr3, mmu_cycle3;
  seq_state_t dbg_state3;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  tpu_seq_ctrl #(.N(N2)) u_dut2 (
    .clk(clk), .rst(rst), .load_en(load_en2), .mode_cont(mode_cont2),
    .load_ready(load_ready2), .mem_addr(mem_addr2), .mem_bank_wr(mem_bank_wr2),
    .mem_bank_rd(mem_bank_rd2), .mmu_en(mmu_en2), .mmu_cycle(mmu_cycle2),
    .res_valid(res_valid2), .done(done2), .busy(busy2), .dbg_state(dbg_state2)
  );

  tpu_seq_ctrl #(.N(N3)) u_dut3 (
    .clk(clk), .rst(rst), .load_en(load_en3), .mode_cont(mode_cont3),
    .load_ready(load_ready3), .mem_addr(mem_addr3), .mem_bank_wr(mem_bank_wr3),
    .mem_bank_rd(mem_bank_rd3), .mmu_en(mmu_en3), .mmu_cycle(mmu_cycle3),
    .res_valid(res_valid3), .done(done3), .busy(busy3), .dbg_state(dbg_state3)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; drives inputs for one cycle and returns at the next
  // negedge with the post-edge outputs settled. acc reports a transfer.
  task automatic step2(input logic le, input logic mc, output logic acc);
    load_en2 = le; mode_cont2 = mc;
    acc = le && load_ready2;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic step3(input logic le, input logic mc, output logic acc);
    load_en3 = le; mode_cont3 = mc;
    acc = le && load_ready3;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic do_reset();
    logic a;
    @(negedge clk);
    rst = 1'b0;
    load_en2 = 1'b0; mode_cont2 = 1'b0; load_en3 = 1'b0; mode_cont3 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    step2(1'b0, 1'b0, a);
  endtask

  // Loads one N=2 block from IDLE; random host stalls when rnd is set.
  task automatic load_block2(input bit rnd, input logic mc, input string tag);
    int   cnt = 0;
    int   guard = 0;
    logic a;
    while (cnt < E2 && guard < 200) begin
      step2(rnd ? ($urandom_range(0, 3) != 0) : 1'b1, mc, a);
      guard++;
      if (a) cnt++;
      checks++;
      if (mem_addr2 !== 3'(cnt % E2)) begin
        errors++; $display("FAIL %s load mem_addr got %0d want %0d", tag, mem_addr2, cnt % E2);
      end
      checks++;
      if (mmu_en2 !== (cnt == E2) || busy2 !== (cnt > 0)) begin
        errors++; $display("FAIL %s load mmu_en/busy got %0b/%0b want %0b/%0b", tag, mmu_en2, busy2, cnt == E2, cnt > 0);
      end
    end
    checks++;
    if (cnt < E2) begin
      errors++; $display("FAIL %s load timeout got %0d accepts want %0d", tag, cnt, E2);
    end
  endtask

  // Single-shot N=2 matmul from IDLE through to the return to IDLE.
  task automatic run_single_shot(input string tag);
    logic a;
    load_block2(1'b1, 1'b0, tag);
    checks++;
    if (mmu_cycle2 !== 3'd0 || mem_bank_rd2 !== 1'b0 || mem_bank_wr2 !== 1'b1) begin
      errors++; $display("FAIL %s run start cyc/rd/wr got %0d/%0b/%0b want 0/0/1", tag, mmu_cycle2, mem_bank_rd2, mem_bank_wr2);
    end
    for (int t = 1; t <= P2; t++) begin
      step2(1'b0, 1'b0, a);
      if (t < P2) begin
        checks++;
        if (mmu_cycle2 !== 3'(t) || done2 !== (t == OFF2) || res_valid2 !== (t >= OFF2)) begin
          errors++; $display("FAIL %s run t=%0d cyc/done/rv got %0d/%0b/%0b want %0d/%0b/%0b", tag, t, mmu_cycle2, done2, res_valid2, t, t == OFF2, t >= OFF2);
        end
        checks++;
        if (mmu_en2 !== 1'b1 || load_ready2 !== 1'b0) begin
          errors++; $display("FAIL %s run t=%0d mmu_en/load_ready got %0b/%0b want 1/0", tag, t, mmu_en2, load_ready2);
        end
      end else begin
        checks++;
        if ({busy2, mmu_en2, res_valid2, done2, mem_addr2} !== 7'd0 || load_ready2 !== 1'b1) begin
          errors++; $display("FAIL %s idle busy/en/rv/addr got %0b/%0b/%0b/%0d want 0/0/0/0", tag, busy2, mmu_en2, res_valid2, mem_addr2);
        end
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({load_ready2, mem_addr2, mem_bank_wr2, mem_bank_rd2, mmu_en2, mmu_cycle2, res_valid2, done2, busy2} !== '0) begin
      errors++; $display("FAIL reset n2 outputs got nonzero want all 0");
    end
    checks++;
    if ({load_ready3, mem_addr3, mem_bank_wr3, mem_bank_rd3, mmu_en3, mmu_cycle3, res_valid3, done3, busy3} !== '0) begin
      errors++; $display("FAIL reset n3 outputs got nonzero want all 0");
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (load_ready2 !== 1'b1 || busy2 !== 1'b0 || mmu_en2 !== 1'b0) begin
      errors++; $display("FAIL reset release ready/busy/en got %0b/%0b/%0b want 1/0/0", load_ready2, busy2, mmu_en2);
    end
  endtask

  task automatic test_single_shot();
    do_reset();
    run_single_shot("single");
  endtask

  // 16 unbroken accepts in continuous mode: the 16th lands on the wrap edge.
  task automatic test_back_to_back();
    logic a;
    int   t;
    do_reset();
    for (int s = 1; s <= 24; s++) begin
      step2(s <= 16, 1'b1, a);
      if (s <= 16) begin
        checks++;
        if (a !== 1'b1) begin
          errors++; $display("FAIL b2b accept s=%0d got 0 want 1", s);
        end
      end
      if (s < 8) begin
        checks++;
        if (mem_addr2 !== 3'(s % E2) || mmu_en2 !== 1'b0) begin
          errors++; $display("FAIL b2b load s=%0d addr/en got %0d/%0b want %0d/0", s, mem_addr2, mmu_en2, s % E2);
        end
      end else begin
        t = s - 8;
        if (t < 2 * P2) begin
          checks++;
          if (mmu_en2 !== 1'b1 || mmu_cycle2 !== 3'(t % P2) || done2 !== ((t % P2) == OFF2) || res_valid2 !== ((t % P2) >= OFF2)) begin
            errors++; $display("FAIL b2b run t=%0d en/cyc/done/rv got %0b/%0d/%0b/%0b want 1/%0d/%0b/%0b", t, mmu_en2, mmu_cycle2, done2, res_valid2, t % P2, (t % P2) == OFF2, (t % P2) >= OFF2);
          end
          checks++;
          if (mem_bank_rd2 !== 1'((t / P2) % 2) || mem_bank_wr2 !== 1'(1 - (t / P2) % 2)) begin
            errors++; $display("FAIL b2b bank t=%0d rd/wr got %0b/%0b want %0d/%0d", t, mem_bank_rd2, mem_bank_wr2, (t / P2) % 2, 1 - (t / P2) % 2);
          end
          checks++;
          if (mem_addr2 !== ((s <= 16) ? 3'(s % E2) : 3'd0)) begin
            errors++; $display("FAIL b2b run t=%0d mem_addr got %0d", t, mem_addr2);
          end
        end else begin
          checks++;
          if (mmu_en2 !== 1'b0 || busy2 !== 1'b1 || mem_addr2 !== 3'd0 || mmu_cycle2 !== 3'd0 || res_valid2 !== 1'b0) begin
            errors++; $display("FAIL b2b to load en/busy/addr/cyc got %0b/%0b/%0d/%0d want 0/1/0/0", mmu_en2, busy2, mem_addr2, mmu_cycle2);
          end
        end
      end
    end
    load_en2 = 1'b0;
  endtask

  // N=3: next block only 17/18 loaded at the wrap, finished after a stall in LOAD.
  task automatic test_stall_n3();
    int   cnt = 0;
    int   guard = 0;
    int   k;
    logic a;
    do_reset();
    while (cnt < E3 && guard < 300) begin
      step3($urandom_range(0, 2) != 0, 1'b1, a);
      guard++;
      if (a) cnt++;
      checks++;
      if (mem_addr3 !== 5'(cnt % E3) || mmu_en3 !== (cnt == E3)) begin
        errors++; $display("FAIL n3 load addr/en got %0d/%0b want %0d/%0b", mem_addr3, mmu_en3, cnt % E3, cnt == E3);
      end
    end
    checks++;
    if (cnt < E3) begin
      errors++; $display("FAIL n3 load timeout got %0d accepts want %0d", cnt, E3);
    end
    for (int t = 1; t <= P3; t++) begin
      step3(t <= E3 - 1, 1'b1, a);
      if (t <= E3 - 1) begin
        checks++;
        if (a !== 1'b1) begin
          errors++; $display("FAIL n3 run accept t=%0d got 0 want 1", t);
        end
      end
      if (t < P3) begin
        checks++;
        if (mmu_cycle3 !== 5'(t) || done3 !== (t == OFF3) || res_valid3 !== (t >= OFF3) || mem_addr3 !== 5'(t)) begin
          errors++; $display("FAIL n3 run t=%0d cyc/done/rv/addr got %0d/%0b/%0b/%0d want %0d/%0b/%0b/%0d", t, mmu_cycle3, done3, res_valid3, mem_addr3, t, t == OFF3, t >= OFF3, t);
        end
      end else begin
        checks++;
        if (mmu_en3 !== 1'b0 || busy3 !== 1'b1 || mem_addr3 !== 5'(E3 - 1) || mmu_cycle3 !== 5'd0) begin
          errors++; $display("FAIL n3 wrap to load en/busy/addr/cyc got %0b/%0b/%0d/%0d want 0/1/%0d/0", mmu_en3, busy3, mem_addr3, mmu_cycle3, E3 - 1);
        end
      end
    end
    k = $urandom_range(1, 6);
    for (int i = 0; i < k; i++) begin
      step3(1'b0, 1'b1, a);
      checks++;
      if (mem_addr3 !== 5'(E3 - 1) || mmu_en3 !== 1'b0) begin
        errors++; $display("FAIL n3 stall addr/en got %0d/%0b want %0d/0", mem_addr3, mmu_en3, E3 - 1);
      end
    end
    step3(1'b1, 1'b1, a);
    checks++;
    if (mmu_en3 !== 1'b1 || mmu_cycle3 !== 5'd0 || mem_bank_rd3 !== 1'b1 || mem_addr3 !== 5'd0) begin
      errors++; $display("FAIL n3 restart en/cyc/rd/addr got %0b/%0d/%0b/%0d want 1/0/1/0", mmu_en3, mmu_cycle3, mem_bank_rd3, mem_addr3);
    end
    for (int d = 1; d <= OFF3; d++) begin
      step3(1'b0, 1'b1, a);
      checks++;
      if (done3 !== (d == OFF3)) begin
        errors++; $display("FAIL n3 done d=%0d got %0b want %0b", d, done3, d == OFF3);
      end
    end
    load_en3 = 1'b0;
  endtask

  // mode_cont dropped mid-period with 5 elements of the next block loaded.
  task automatic test_drop_mode();
    logic a;
    do_reset();
    load_block2(1'b0, 1'b1, "drop");
    for (int t = 1; t <= P2; t++) begin
      step2(1'b1, t < 5, a);
      checks++;
      if (a !== (t <= 5)) begin
        errors++; $display("FAIL drop accept t=%0d got %0b want %0b", t, a, t <= 5);
      end
      if (t < P2) begin
        checks++;
        if (mmu_cycle2 !== 3'(t) || done2 !== (t == OFF2) || res_valid2 !== (t >= OFF2) || mem_addr2 !== 3'((t < 5) ? t : 5)) begin
          errors++; $display("FAIL drop run t=%0d cyc/done/rv/addr got %0d/%0b/%0b/%0d", t, mmu_cycle2, done2, res_valid2, mem_addr2);
        end
      end else begin
        checks++;
        if (busy2 !== 1'b0 || mmu_en2 !== 1'b0 || res_valid2 !== 1'b0 || mem_addr2 !== 3'd0) begin
          errors++; $display("FAIL drop idle busy/en/rv/addr got %0b/%0b/%0b/%0d want 0/0/0/0", busy2, mmu_en2, res_valid2, mem_addr2);
        end
      end
    end
    load_en2 = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    logic a;
    do_reset();
    load_block2(1'b0, 1'b0, "midrst");
    repeat (3) step2(1'b0, 1'b0, a);
    checks++;
    if (mmu_cycle2 !== 3'd3 || mmu_en2 !== 1'b1) begin
      errors++; $display("FAIL midrst before cyc/en got %0d/%0b want 3/1", mmu_cycle2, mmu_en2);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({load_ready2, mem_addr2, mem_bank_wr2, mem_bank_rd2, mmu_en2, mmu_cycle2, res_valid2, done2, busy2} !== '0) begin
      errors++; $display("FAIL midrst async clear got en=%0b cyc=%0d busy=%0b want all 0", mmu_en2, mmu_cycle2, busy2);
    end
    @(negedge clk);
    rst = 1'b1;
    step2(1'b0, 1'b0, a);
    run_single_shot("after_rst");
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_shot();
    test_back_to_back();
    test_stall_n3();
    test_drop_mode();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
